// File: rtl/synth_pkg.sv
// Shared constants and types for the chiptune synthesizer: note increments,
// waveform modes and the noise LFSR seed.
package synth_pkg;

  localparam int LFSR_W = 15;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF;

  // Phase increment per sample tick for each note; entry 0 is the reference pitch.
  localparam logic [7:0] NOTE_INC [0:7] = '{
    8'd128, 8'd144, 8'd161, 8'd171, 8'd192, 8'd215, 8'd228, 8'd255
  };

  typedef enum logic [1:0] {
    MODE_SQUARE50 = 2'd0,
    MODE_PULSE25  = 2'd1,
    MODE_NOISE    = 2'd2,
    MODE_OFF      = 2'd3
  } mode_t;

endpackage

// File: rtl/synth_voice.sv
// One synthesizer voice: phase accumulator, decaying envelope, noise LFSR and
// waveform select. The sample is vol when the waveform bit is high, else 0.
module synth_voice
  import synth_pkg::*;
#(
  parameter int PHASE_W     = 16,
  parameter int VOL_W       = 6,
  parameter int DECAY_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_tick,
  input  logic             env_tick,
  input  logic             load,
  input  logic [2:0]       load_note,
  input  logic [1:0]       load_oct,
  input  mode_t            load_mode,
  output logic [VOL_W-1:0] sample
);

  localparam int IDX_W = $clog2(PHASE_W);
  localparam logic [VOL_W-1:0] VOL_MAX = {VOL_W{1'b1}};

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;
  logic [VOL_W-1:0]   vol;
  logic [2:0]         note;
  logic [1:0]         oct;
  mode_t              mode;
  logic [LFSR_W-1:0]  lfsr;
  logic [IDX_W-1:0]   idx_hi;
  logic [IDX_W-1:0]   idx_lo;
  logic               rise;
  logic               wave_bit;

  // Higher octaves tap lower phase bits, doubling the frequency per octave.
  assign idx_hi     = IDX_W'(PHASE_W - 4) + IDX_W'(2'd3 - oct);
  assign idx_lo     = idx_hi - IDX_W'(1);
  assign phase_next = phase + PHASE_W'(NOTE_INC[note]);
  assign rise       = ~phase[idx_hi] & phase_next[idx_hi];

  always_comb begin
    wave_bit = 1'b0;
    case (mode)
      MODE_SQUARE50: wave_bit = phase[idx_hi];
      MODE_PULSE25:  wave_bit = phase[idx_hi] & phase[idx_lo];
      MODE_NOISE:    wave_bit = lfsr[0];
      default:       wave_bit = 1'b0;
    endcase
  end

  assign sample = wave_bit ? vol : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      vol   <= '0;
      note  <= '0;
      oct   <= '0;
      mode  <= MODE_OFF;
      lfsr  <= LFSR_SEED;
    end else if (load) begin
      phase <= '0;
      vol   <= VOL_MAX;
      note  <= load_note;
      oct   <= load_oct;
      mode  <= load_mode;
      lfsr  <= LFSR_SEED;
    end else begin
      if (sample_tick) begin
        phase <= phase_next;
        // Noise is clocked by the pitch: one LFSR step per rising edge of the tap bit.
        if (mode == MODE_NOISE && rise) begin
          lfsr <= {lfsr[LFSR_W-2:0], lfsr[14] ^ lfsr[13]};
        end
      end
      if (env_tick) begin
        vol <= vol - (vol >> DECAY_SHIFT);
      end
    end
  end

endmodule

// File: rtl/chiptune_synth.sv
// Multi-voice chiptune synthesizer: command decode, NUM_VOICES voices, mixer
// and a first-order delta-sigma modulator producing 1-bit audio.
module chiptune_synth
  import synth_pkg::*;
#(
  parameter int NUM_VOICES  = 2,
  parameter int PHASE_W     = 16,
  parameter int VOL_W       = 6,
  parameter int DECAY_SHIFT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       env_tick,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_voice,
  input  logic [2:0] cmd_note,
  input  logic [1:0] cmd_oct,
  input  logic [1:0] cmd_mode,
  output logic       audio_pwm
);

  localparam int MIX_W = VOL_W + $clog2(NUM_VOICES);

  logic             accept;
  logic [VOL_W-1:0] samples [NUM_VOICES];
  logic [MIX_W-1:0] mix;
  logic [MIX_W-1:0] acc;
  logic [MIX_W:0]   acc_sum;

  assign accept = cmd_valid & cmd_ready;

  // Commands for non-existent voices match no load strobe and are simply dropped.
  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : gen_voice
      logic load;
      assign load = accept && (cmd_voice == 3'(gi));

      synth_voice #(
        .PHASE_W     (PHASE_W),
        .VOL_W       (VOL_W),
        .DECAY_SHIFT (DECAY_SHIFT)
      ) u_voice (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .env_tick    (env_tick),
        .load        (load),
        .load_note   (cmd_note),
        .load_oct    (cmd_oct),
        .load_mode   (mode_t'(cmd_mode)),
        .sample      (samples[gi])
      );
    end
  endgenerate

  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix = mix + MIX_W'(samples[i]);
    end
  end

  assign acc_sum = {1'b0, acc} + {1'b0, mix};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      audio_pwm <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      acc       <= acc_sum[MIX_W-1:0];
      audio_pwm <= acc_sum[MIX_W];
      cmd_ready <= ~accept;
    end
  end

endmodule

// File: tb/tb_chiptune_synth.sv
// Bench for chiptune_synth: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of voices, mixer and modulator.
module tb_chiptune_synth;

  localparam int NV     = 2;
  localparam int MIXMOD = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       env_tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_voice = '0;
  logic [2:0] cmd_note = '0;
  logic [1:0] cmd_oct = '0;
  logic [1:0] cmd_mode = '0;
  logic       cmd_ready;
  logic       audio_pwm;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  int note_inc [8] = '{128, 144, 161, 171, 192, 215, 228, 255};
  int m_ph [NV];
  int m_vol [NV];
  int m_note [NV];
  int m_oct [NV];
  int m_mode [NV];
  int m_lfsr [NV];
  int m_acc = 0;
  bit m_pwm = 1'b0;
  bit m_ready = 1'b0;

  chiptune_synth #(
    .NUM_VOICES (NV), .PHASE_W (16), .VOL_W (6), .DECAY_SHIFT (3)
  ) dut (
    .clk (clk), .rst_n (rst_n), .sample_tick (sample_tick), .env_tick (env_tick),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_voice (cmd_voice),
    .cmd_note (cmd_note), .cmd_oct (cmd_oct), .cmd_mode (cmd_mode),
    .audio_pwm (audio_pwm)
  );

  always #5 clk = ~clk;

  function automatic int bit_at(int x, int p);
    return (x >> p) & 1;
  endfunction

  // Waveform bit: octave o reads phase bit 15-o; pulse25 also needs the bit below.
  function automatic bit m_out(int v);
    int p;
    p = 15 - m_oct[v];
    case (m_mode[v])
      0:       return bit_at(m_ph[v], p) == 1;
      1:       return bit_at(m_ph[v], p) == 1 && bit_at(m_ph[v], p - 1) == 1;
      2:       return (m_lfsr[v] & 1) == 1;
      default: return 1'b0;
    endcase
  endfunction

  // x^15 + x^14 + 1: feedback from the 15th and 14th stages, shifted in at stage 1.
  function automatic int lfsr_next(int s);
    int fb;
    fb = bit_at(s, 14) ^ bit_at(s, 13);
    return ((s << 1) | fb) & 'h7FFF;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_ph[v] = 0; m_vol[v] = 0; m_note[v] = 0; m_oct[v] = 0;
      m_mode[v] = 3; m_lfsr[v] = 'h7FFF;
    end
    m_acc = 0; m_pwm = 1'b0; m_ready = 1'b0;
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        int mix, np, p;
        bit take;
        mix = 0;
        for (int v = 0; v < NV; v++) if (m_out(v)) mix += m_vol[v];
        m_acc = m_acc + mix;
        m_pwm = (m_acc >= MIXMOD);
        m_acc = m_acc % MIXMOD;
        take = cmd_valid && m_ready;
        m_ready = !take;
        for (int v = 0; v < NV; v++) begin
          if (take && int'(cmd_voice) == v) begin
            m_vol[v] = 63; m_ph[v] = 0; m_lfsr[v] = 'h7FFF;
            m_note[v] = int'(cmd_note); m_oct[v] = int'(cmd_oct); m_mode[v] = int'(cmd_mode);
          end else begin
            if (sample_tick) begin
              p = 15 - m_oct[v];
              np = (m_ph[v] + note_inc[m_note[v]]) % 65536;
              if (m_mode[v] == 2 && bit_at(m_ph[v], p) == 0 && bit_at(np, p) == 1)
                m_lfsr[v] = lfsr_next(m_lfsr[v]);
              m_ph[v] = np;
            end
            if (env_tick) m_vol[v] = m_vol[v] - m_vol[v] / 8;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_checks++;
        if (audio_pwm !== m_pwm) begin
          n_errors++;
          $display("FAIL audio_pwm @%0t: got %b expected %b", $time, audio_pwm, m_pwm);
        end
        n_checks++;
        if (cmd_ready !== m_ready) begin
          n_errors++;
          $display("FAIL cmd_ready @%0t: got %b expected %b", $time, cmd_ready, m_ready);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s ok (%0d)", name, act);
    end
  endtask

  task automatic cyc(input bit st, input bit et, input bit cv,
                     input int voice, input int note, input int oct, input int mode);
    @(negedge clk);
    #1;
    sample_tick = st; env_tick = et; cmd_valid = cv;
    cmd_voice = 3'(voice); cmd_note = 3'(note); cmd_oct = 2'(oct); cmd_mode = 2'(mode);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmd(input int voice, input int note, input int oct, input int mode);
    cyc(0, 0, 1, voice, note, oct, mode);
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); #1; rst_n = 1'b0;
    repeat (n) @(negedge clk);
    #1; rst_n = 1'b1;
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (audio_pwm) hi++;
    end
  endtask

  initial begin : stim
    int hi, first, second, steps, prev_lfsr;
    bit prev_b, b;
    int rdy [3];
    int exp_lfsr [4] = '{'h7FFE, 'h7FFC, 'h7FF8, 'h7FF0};
    int exp_tick [4] = '{32, 96, 160, 224};
    int exp_vol [3] = '{56, 49, 43};

    @(posedge clk); #1; chk_en = 1'b1;

    // Reset held with activity on the inputs: output must stay silent.
    sample_tick = 1'b1; cmd_valid = 1'b1;
    count_high(1000, hi);
    check("reset_pwm_highs", hi, 0);
    sample_tick = 1'b0; cmd_valid = 1'b0;
    rst_n = 1'b1;
    idle(2);
    check("ready_after_release", int'(cmd_ready), 1);

    // Square50 at octave 3 with increment 128 toggles every 32 sample ticks.
    cmd(0, 0, 3, 0);
    check("trig_vol", m_vol[0], 63);
    first = -1; second = -1; prev_b = m_out(0);
    for (int k = 1; k <= 70; k++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      settle();
      b = m_out(0);
      if (b != prev_b) begin
        if (first < 0) first = k; else if (second < 0) second = k;
      end
      prev_b = b;
    end
    idle(1);
    check("square_first_toggle", first, 32);
    check("square_second_toggle", second, 64);

    // Envelope decay and command priority over env_tick.
    cmd(1, 0, 3, 0);
    check("v1_trig_vol", m_vol[1], 63);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      settle();
      check($sformatf("v1_decay_%0d", k), m_vol[1], exp_vol[k]);
    end
    cyc(0, 1, 1, 1, 0, 3, 0);
    settle();
    check("v1_trig_on_env", m_vol[1], 63);
    check("v0_decay_same_cycle", m_vol[0], 38);
    idle(3);

    // Both voices at full volume and high: 126 of 128; then one voice: 63 of 128.
    do_reset(2);
    cmd(0, 0, 3, 0);
    cmd(1, 0, 3, 0);
    repeat (32) cyc(1, 0, 0, 0, 0, 0, 0);
    idle(4);
    count_high(128, hi);
    check("pwm_mix126", hi, 126);
    cmd(1, 0, 3, 3);
    idle(4);
    count_high(128, hi);
    check("pwm_mix63", hi, 63);

    // Back-to-back commands to a non-existent voice.
    idle(2);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 5, 1, 1, 1);
      rdy[i] = int'(cmd_ready);
    end
    idle(2);
    check("b2b_ready0", rdy[0], 1);
    check("b2b_ready1", rdy[1], 0);
    check("b2b_ready2", rdy[2], 1);
    check("discard_v0_vol", m_vol[0], 63);
    check("discard_v1_mode", m_mode[1], 3);

    // Noise: LFSR advances only on rising edges of the octave tap bit.
    do_reset(2);
    cmd(0, 0, 3, 2);
    check("noise_seed", m_lfsr[0], 'h7FFF);
    check("noise_out_seed", int'(m_out(0)), 1);
    steps = 0; prev_lfsr = m_lfsr[0];
    for (int k = 1; k <= 230; k++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      settle();
      if (m_lfsr[0] != prev_lfsr) begin
        if (steps < 4) begin
          check($sformatf("noise_lfsr_%0d", steps), m_lfsr[0], exp_lfsr[steps]);
          check($sformatf("noise_tick_%0d", steps), k, exp_tick[steps]);
          check($sformatf("noise_out_%0d", steps), int'(m_out(0)), 0);
        end
        steps++;
        prev_lfsr = m_lfsr[0];
      end
    end
    check("noise_steps", steps, 4);
    idle(2);

    // Randomized traffic with one mid-run reset; compared every cycle.
    for (int i = 0; i < 6000; i++) begin
      if (i == 3000) do_reset(3);
      cyc($urandom_range(2) == 0, $urandom_range(63) == 0, $urandom_range(7) == 0,
          int'($urandom_range(7)), int'($urandom_range(7)),
          int'($urandom_range(3)), int'($urandom_range(3)));
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
